uart_cmd_master: RTL and testbench

- Host-side command initiator for the UART register/ALU system.
- Accepts one command per handshake and encodes it into the system's command frame as a stream of bytes for a byte-level UART transmitter.
- Then waits for the single response byte from a byte-level UART receiver, or declares a timeout.
- Used as the bench/host driver and on boards where an on-chip controller talks to the system over UART.

---
 rtl/uart_cmd_master.sv | 112 +++++++++++
 tb/tb_uart_cmd_master.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: encodes one host command into a UART byte frame, then
// waits for the single response byte or times out.
module uart_cmd_master #(
    parameter int Data_width     = 8,
    parameter int Address_width  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [Address_width-1:0] cmd_addr,
    input  logic [Data_width-1:0]    cmd_data,
    input  logic [Data_width-1:0]    cmd_op_a,
    input  logic [Data_width-1:0]    cmd_op_b,
    input  logic [3:0]               cmd_fun,
    output logic [Data_width-1:0]    tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [Data_width-1:0]    rx_byte,
    input  logic                     rx_valid,
    output logic [Data_width-1:0]    rsp_data,
    output logic                     done,
    output logic                     rsp_valid,
    output logic                     rsp_timeout,
    output logic                     busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t                state;
    logic [Data_width-1:0] f1, f2, f3;
    logic [Data_width-1:0] nf0, nf1, nf2, nf3, next_byte;
    logic [1:0]            idx, last, nlast, idx_inc;
    logic                  has_rsp;
    logic [CW-1:0]         cnt;

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign tx_valid  = state == SEND;
    assign done      = state == DONE;
    assign idx_inc   = idx + 2'd1;

    // Frame bytes 1..3 depend on the command type; the header is byte 0.
    always_comb begin
        nf0   = cmd_type == 2'd0 ? Data_width'(8'hAA) :
                cmd_type == 2'd1 ? Data_width'(8'hBB) :
                cmd_type == 2'd2 ? Data_width'(8'hCC) : Data_width'(8'hDD);
        nf1   = cmd_type == 2'd2 ? cmd_op_a :
                cmd_type == 2'd3 ? Data_width'(cmd_fun) : Data_width'(cmd_addr);
        nf2   = cmd_type == 2'd2 ? cmd_op_b : cmd_data;
        nf3   = Data_width'(cmd_fun);
        nlast = cmd_type == 2'd0 ? 2'd2 : cmd_type == 2'd2 ? 2'd3 : 2'd1;
        next_byte = idx_inc == 2'd1 ? f1 : idx_inc == 2'd2 ? f2 : f3;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            idx         <= '0;
            last        <= '0;
            has_rsp     <= 1'b0;
            cnt         <= '0;
            f1          <= '0;
            f2          <= '0;
            f3          <= '0;
            tx_byte     <= '0;
            rsp_data    <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    f1      <= nf1;
                    f2      <= nf2;
                    f3      <= nf3;
                    tx_byte <= nf0;
                    last    <= nlast;
                    has_rsp <= cmd_type != 2'd0;
                    idx     <= '0;
                    state   <= SEND;
                end
                SEND: if (tx_ready) begin
                    if (idx == last) begin
                        cnt   <= '0;
                        state <= has_rsp ? WAIT : DONE;
                    end else begin
                        idx     <= idx_inc;
                        tx_byte <= next_byte;
                    end
                end
                // A response arriving on the terminal count beats the timeout.
                WAIT: if (rx_valid) begin
                    rsp_data  <= rx_byte;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_timeout <= 1'b1;
                    state       <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: directed checks of framing, handshake pacing, response
// capture, timeout, stray rx and mid-frame reset.
module tb_uart_cmd_master;
    logic       CLK = 0, RST = 1;
    logic       cmd_valid = 0, cmd_ready;
    logic [1:0] cmd_type = 0;
    logic [3:0] cmd_addr = 0, cmd_fun = 0;
    logic [7:0] cmd_data = 0, cmd_op_a = 0, cmd_op_b = 0;
    logic [7:0] tx_byte, rx_byte = 0, rsp_data;
    logic       tx_valid, tx_ready = 0, rx_valid = 0;
    logic       done, rsp_valid, rsp_timeout, busy;
    int         checks = 0, errors = 0;

    uart_cmd_master #(.Data_width(8), .Address_width(4), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rsp_data(rsp_data),
        .done(done), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] d,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        cmd_type = t; cmd_addr = ad; cmd_data = d; cmd_op_a = a; cmd_op_b = b; cmd_fun = f;
        cmd_valid = 1;
        @(negedge CLK);
        cmd_valid = 0;
        cmd_type = ~t; cmd_addr = ~ad; cmd_data = ~d; cmd_op_a = ~a; cmd_op_b = ~b; cmd_fun = ~f;
    endtask

    // Bytes packed MSB-first; tx_ready pulses on the last cycle of each gap.
    task automatic expect_frame(input string tag, input logic [31:0] fr, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < gap; k++) begin
                tx_ready = (k == gap - 1);
                check({tag, "_valid"}, tx_valid, 1);
                check({tag, "_byte"}, tx_byte, fr[31 - 8 * i -: 8]);
                @(negedge CLK);
            end
        end
        tx_ready = 0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_ready", cmd_ready, 1);
        check("rst_txv", tx_valid, 0);
        check("rst_txb", tx_byte, 0);
        check("rst_rsp", rsp_data, 0);
        check("rst_done", done, 0);
        check("rst_rv", rsp_valid, 0);
        check("rst_to", rsp_timeout, 0);
        check("rst_busy", busy, 0);
        RST = 0;
        @(negedge CLK);

        // REG_WR, tx_ready effectively high every cycle
        do_cmd(0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
        check("wr_busy", busy, 1);
        check("wr_ready", cmd_ready, 0);
        expect_frame("wr", 32'hAA053C00, 3, 1);
        check("wr_done", done, 1);
        check("wr_rv", rsp_valid, 0);
        check("wr_to", rsp_timeout, 0);
        check("wr_txv", tx_valid, 0);
        @(negedge CLK);
        check("wr_idle", cmd_ready, 1);
        check("wr_done0", done, 0);

        // REG_RD, tx_ready one cycle in four, response after 10 cycles
        do_cmd(1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
        expect_frame("rd", 32'hBB020000, 2, 4);
        check("rd_txv", tx_valid, 0);
        for (int k = 0; k < 10; k++) begin
            check("rd_wait", done, 0);
            @(negedge CLK);
        end
        rx_valid = 1; rx_byte = 8'h81;
        @(negedge CLK);
        rx_valid = 0;
        check("rd_done", done, 1);
        check("rd_rv", rsp_valid, 1);
        check("rd_to", rsp_timeout, 0);
        check("rd_data", rsp_data, 8'h81);
        @(negedge CLK);
        check("rd_done0", done, 0);
        check("rd_rv0", rsp_valid, 0);
        check("rd_hold", rsp_data, 8'h81);

        // ALU_OP with cmd_valid held high throughout
        cmd_type = 2; cmd_op_a = 8'h14; cmd_op_b = 8'h07; cmd_fun = 4'h0; cmd_valid = 1;
        @(negedge CLK);
        expect_frame("alu", 32'hCC140700, 4, 1);
        check("alu_busy", cmd_ready, 0);
        repeat (3) @(negedge CLK);
        rx_valid = 1; rx_byte = 8'h1B;
        @(negedge CLK);
        rx_valid = 0;
        check("alu_done", done, 1);
        check("alu_rv", rsp_valid, 1);
        check("alu_data", rsp_data, 8'h1B);
        cmd_type = 3; cmd_fun = 4'h3;
        @(negedge CLK);
        check("alu_idle", cmd_ready, 1);
        @(negedge CLK);
        cmd_valid = 0; cmd_type = 0; cmd_fun = 4'hF;

        // ALU_NOP accepted from the held cmd_valid; no response -> timeout
        expect_frame("nop", 32'hDD030000, 2, 1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (k < 16) check("to_wait", done, 0);
        end
        check("to_done", done, 1);
        check("to_flag", rsp_timeout, 1);
        check("to_rv", rsp_valid, 0);
        check("to_data", rsp_data, 8'h1B);
        @(negedge CLK);

        // Response exactly on the terminal count wins
        do_cmd(3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h6);
        expect_frame("nop2", 32'hDD060000, 2, 1);
        repeat (15) @(negedge CLK);
        check("term_wait", done, 0);
        rx_valid = 1; rx_byte = 8'h5A;
        @(negedge CLK);
        rx_valid = 0;
        check("term_done", done, 1);
        check("term_rv", rsp_valid, 1);
        check("term_to", rsp_timeout, 0);
        check("term_data", rsp_data, 8'h5A);
        @(negedge CLK);

        // Stray rx_valid in IDLE and in SEND is ignored
        rx_valid = 1; rx_byte = 8'hEE;
        @(negedge CLK);
        rx_valid = 0;
        check("stray_idle_data", rsp_data, 8'h5A);
        check("stray_idle_ready", cmd_ready, 1);
        check("stray_idle_done", done, 0);
        do_cmd(0, 4'hA, 8'h55, 8'h00, 8'h00, 4'h0);
        rx_valid = 1;
        @(negedge CLK);
        rx_valid = 0;
        check("stray_send_data", rsp_data, 8'h5A);
        expect_frame("wr2", 32'hAA0A5500, 3, 2);
        check("wr2_done", done, 1);
        check("wr2_rv", rsp_valid, 0);
        @(negedge CLK);

        // Reset during the second byte of ALU_OP
        do_cmd(2, 4'h0, 8'h00, 8'h11, 8'h22, 4'h9);
        tx_ready = 1;
        @(negedge CLK);
        tx_ready = 0;
        check("rst_mid_byte", tx_byte, 8'h11);
        #2 RST = 1;
        #1;
        check("rst_mid_txv", tx_valid, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_busy", busy, 0);
        @(negedge CLK);
        RST = 0;
        for (int k = 0; k < 3; k++) begin
            check("rst_mid_done", done, 0);
            @(negedge CLK);
        end
        do_cmd(1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
        expect_frame("rd2", 32'hBB070000, 2, 1);
        @(negedge CLK);
        rx_valid = 1; rx_byte = 8'h3C;
        @(negedge CLK);
        rx_valid = 0;
        check("rd2_done", done, 1);
        check("rd2_rv", rsp_valid, 1);
        check("rd2_data", rsp_data, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
